// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Front-end sequencer for a 5-stage RISC-V pipeline. It resolves load-use
//   hazards, taken branches from EX and multi-cycle instruction fetches. It
//   also drops a wrong-path fetch that returns after a branch redirect.
// Ports:
//   clk, reset           clock, async active-high reset
//   if_id_rs1/rs2        source register fields of the ID instruction
//   if_id_uses_rs2       ID instruction reads rs2
//   id_ex_mem_read/rd    EX instruction is a load / its destination register
//   ex_branch_taken      taken branch/jump resolved in EX
//   imem_ready           current fetch word is valid
//   pc_write, if_id_write, if_id_flush, id_ex_bubble   pipeline controls
//   state                0 RUN, 1 WAIT, 2 DISCARD
//   stall_cycles, flush_events   saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             lu, eff_ready;

  assign lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
              ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

  // A word arriving in DISCARD belongs to the abandoned path, so it is never
  // treated as a usable fetch.
  assign eff_ready = imem_ready && (state_q != DISCARD);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu) begin
      // Hold IF/ID (even if the fetch is also late) so the stalled
      // instruction survives; only EX gets a bubble.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (!eff_ready) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
    if (ex_branch_taken && (flush_q != {CNT_W{1'b1}}))
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      case (state_q)
        RUN: begin
          if (!imem_ready) state_q <= ex_branch_taken ? DISCARD : WAIT;
        end
        WAIT: begin
          // A branch coinciding with the returned word flushes it directly.
          if (imem_ready)           state_q <= RUN;
          else if (ex_branch_taken) state_q <= DISCARD;
        end
        DISCARD: begin
          if (imem_ready) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Inputs change 1 time unit after a
// rising edge; outputs are sampled 3 units later, mid-cycle.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;

  logic             clk, reset;
  logic [4:0]       rs1, rs2, rd;
  logic             u2, mr, br, rdy;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_chk = 0;
  int n_pass = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_uses_rs2(u2),
    .id_ex_mem_read(mr), .id_ex_rd(rd),
    .ex_branch_taken(br), .imem_ready(rdy),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .state(state), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  wire [3:0] outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic au2,
                       input logic amr, input logic [4:0] ard, input logic abr,
                       input logic ardy);
    rs1 = a1; rs2 = a2; u2 = au2; mr = amr; rd = ard; br = abr; rdy = ardy;
    #3;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  // Check outputs, state and counters at the sampling point.
  task automatic look(input string tag, input logic [3:0] eo, input logic [1:0] es,
                      input int est, input int efl);
    chk({tag, ".outs"},  32'(outs), 32'(eo));
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".stall"}, 32'(stall_cycles), 32'(est));
    chk({tag, ".flush"}, 32'(flush_events), 32'(efl));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    look("reset", 4'b0011, 2'd0, 0, 0);
    tick();
    reset = 1'b0;
    idle();
    look("run", 4'b1100, 2'd0, 0, 0);
    tick();

    // load-use on rs2
    drive(5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
    look("lu", 4'b0001, 2'd0, 0, 0);
    tick();
    idle();
    look("lu_clr", 4'b1100, 2'd0, 1, 0);
    tick();
    // rd = x0 never hazards
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    look("lu_x0", 4'b1100, 2'd0, 1, 0);
    tick();
    // rs2 match ignored when rs2 is not read
    drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
    look("lu_nors2", 4'b1100, 2'd0, 1, 0);
    tick();

    // three-cycle fetch miss
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    look("miss1", 4'b0010, 2'd0, 1, 0);
    tick();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    look("miss2", 4'b0010, 2'd1, 2, 0);
    tick();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    look("miss3", 4'b0010, 2'd1, 3, 0);
    tick();
    idle();
    look("miss_rdy", 4'b1100, 2'd1, 4, 0);
    tick();
    idle();
    look("miss_run", 4'b1100, 2'd0, 4, 0);
    tick();

    // branch while fetch outstanding -> DISCARD; second branch inside DISCARD
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    look("dsc1", 4'b1011, 2'd0, 4, 0);
    tick();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    look("dsc2", 4'b0010, 2'd2, 4, 1);
    tick();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    look("dsc3_br", 4'b1011, 2'd2, 5, 1);
    tick();
    idle();
    look("dsc4_rdy", 4'b0010, 2'd2, 5, 2);
    tick();
    idle();
    look("dsc5_run", 4'b1100, 2'd0, 6, 2);
    tick();

    // branch beats load-use
    drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
    look("br_lu", 4'b1011, 2'd0, 6, 2);
    tick();
    // load-use beats a late fetch
    drive(5'd3, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    look("lu_miss", 4'b0001, 2'd0, 6, 3);
    tick();
    idle();
    look("lu_miss_rdy", 4'b1100, 2'd1, 7, 3);
    tick();

    // stall counter saturation: 12 stall cycles from 7 would reach 19 > 15
    for (int i = 0; i < 12; i++) begin
      drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
    end
    idle();
    look("sat", 4'b1100, 2'd1, 15, 3);
    tick();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    idle();
    look("sat_hold", 4'b1100, 2'd1, 15, 3);
    tick();

    // async reset mid-DISCARD
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    look("pre_rst", 4'b0010, 2'd2, 15, 4);
    reset = 1'b1;
    #1;
    look("async_rst", 4'b0011, 2'd0, 0, 0);
    tick();
    reset = 1'b0;
    idle();
    look("post_rst", 4'b1100, 2'd0, 0, 0);
    tick();
    idle();
    look("post_rst2", 4'b1100, 2'd0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
